// File: rtl/biquad_coeff_sequencer.sv
// Biquad coefficient sequencer.
// A WISHBONE target holds a shadow copy of every channel's coefficients.
// Committing a channel mask streams the selected channels' coefficients,
// one per cycle, to the filter cores. A single update pulse then swaps all
// of those channels together.
module biquad_coeff_sequencer #(
    parameter int NCH         = 4,
    parameter int NCOEFF      = 8,
    parameter int COEFF_BITS  = 18,
    parameter int WB_ADR_BITS = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [WB_ADR_BITS-1:0]    wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic [31:0]               wb_dat_o,
    input  logic                      global_update_i,
    output logic [COEFF_BITS-1:0]     coeff_dat_o,
    output logic [$clog2(NCOEFF)-1:0] coeff_adr_o,
    output logic [NCH-1:0]            coeff_wr_o,
    output logic [NCH-1:0]            update_o,
    output logic                      busy_o
);

    localparam int KB   = $clog2(NCOEFF);
    localparam int CHB  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NENT = NCH * NCOEFF;
    localparam int IB   = $clog2(NENT);

    typedef enum logic [1:0] {IDLE, STREAM, UPDATE} state_t;

    state_t                state_q, state_d;
    logic [COEFF_BITS-1:0] shadow_q [NENT];
    logic [NCH-1:0]        mask_q;
    logic                  err_flag_q;
    logic                  commit_pend_q;
    logic                  gu_pend_q;
    logic                  glob_q;
    logic [CHB-1:0]        ch_q;
    logic [KB-1:0]         k_q;

    logic        req, idle, last_k;
    logic [31:0] adr_ext, status_word;
    logic        is_ctrl, is_status, is_shadow, wr_blocked;
    logic [IB-1:0] sh_idx, st_idx;
    logic [CHB-1:0] first_ch, nxt_ch;
    logic           nxt_found;

    assign wb_rty_o = 1'b0;
    assign idle     = (state_q == IDLE);
    assign last_k   = (k_q == KB'(NCOEFF - 1));

    // Address decode and bus qualification. A new request is only taken while no response is
    // pending, so a held strobe sees a one-cycle gap between acknowledges.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no path infers a latch.
        req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
        adr_ext   = 32'(wb_adr_i);
        is_ctrl   = (adr_ext[31:2] == 30'd0);
        is_status = (adr_ext[31:2] == 30'd1);
        is_shadow = (adr_ext >= 32'h100) && (adr_ext < 32'(256 + 4 * NENT));
        sh_idx    = IB'((adr_ext - 32'h100) >> 2);
        st_idx    = IB'(int'(ch_q) * NCOEFF + int'(k_q));
        wr_blocked = req & wb_we_i & ~idle & (is_shadow | (is_ctrl & wb_dat_i[0]));
        status_word             = '0;
        status_word[0]          = ~idle;
        status_word[1]          = err_flag_q;
        status_word[16 +: NCH]  = mask_q;
    end

    // Lowest masked channel overall, and the next masked channel above the current one.
    always_comb begin
        first_ch  = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = CHB'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_ch    = CHB'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Bus responses, control/status registers and commit request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            wb_dat_o      <= '0;
            err_flag_q    <= 1'b0;
            mask_q        <= '0;
            commit_pend_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every register then
            // samples pre-edge values, whatever the order of the statements.
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            wb_dat_o      <= '0;
            commit_pend_q <= 1'b0;
            if (req) begin
                if (wr_blocked) begin
                    wb_err_o   <= 1'b1;
                    err_flag_q <= 1'b1;
                end else begin
                    wb_ack_o <= 1'b1;
                    if (wb_we_i) begin
                        if (is_ctrl && wb_dat_i[0]) begin
                            mask_q        <= wb_dat_i[16 +: NCH];
                            commit_pend_q <= |wb_dat_i[16 +: NCH];
                        end
                        if (is_status && wb_dat_i[1]) begin
                            err_flag_q <= 1'b0;
                        end
                    end else if (is_status) begin
                        wb_dat_o <= status_word;
                    end else if (is_shadow) begin
                        wb_dat_o <= 32'(shadow_q[sh_idx]);
                    end
                end
            end
        end
    end

    // Shadow coefficient store. Writes are accepted only while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the store must come up cleared, so this array is built from resettable flops
            // rather than a RAM macro.
            for (int i = 0; i < NENT; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (req && wb_we_i && is_shadow && idle && wb_sel_i[0]) begin
            shadow_q[sh_idx] <= wb_dat_i[COEFF_BITS-1:0];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        coeff_wr_o  = '0;
        coeff_adr_o = '0;
        coeff_dat_o = '0;
        update_o    = {NCH{glob_q | (idle & gu_pend_q)}};
        unique case (state_q)
            IDLE: begin
                if (commit_pend_q) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy_o      = 1'b1;
                coeff_wr_o  = NCH'(1) << ch_q;
                coeff_adr_o = k_q;
                coeff_dat_o = shadow_q[st_idx];
                if (last_k && !nxt_found) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy_o   = 1'b1;
                update_o = update_o | mask_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel and coefficient counters. They are preloaded with the first masked channel while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ch_q <= '0;
            k_q  <= '0;
        end else if (state_q == IDLE) begin
            ch_q <= first_ch;
            k_q  <= '0;
        end else if (state_q == STREAM) begin
            if (last_k) begin
                k_q  <= '0;
                ch_q <= nxt_ch;
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Global update requests. A request seen while idle pulses one cycle later. Requests made while
    // busy merge into one pulse in the first idle cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gu_pend_q <= 1'b0;
            glob_q    <= 1'b0;
        end else begin
            glob_q    <= idle & global_update_i;
            gu_pend_q <= idle ? 1'b0 : (gu_pend_q | global_update_i);
        end
    end

endmodule

// File: doc/biquad_coeff_sequencer.md
BIQUAD_COEFF_SEQUENCER -- requirements
Module: biquad_coeff_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of biquad channels served, legal range 1..16.
REQ-002 SHALL have parameter NCOEFF, default 8, the coefficients per channel, a power of 2 in 2..32.
REQ-003 SHALL have parameter COEFF_BITS, default 18, the coefficient width, legal range 1..32.
REQ-004 SHALL have parameter WB_ADR_BITS, default 10, the WISHBONE byte-address width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk_i (in, 1, sole clock) and rst_n_i (in, 1, active-low asynchronous reset).
REQ-006 SHALL have the WISHBONE target inputs wb_cyc_i (in, 1), wb_stb_i (in, 1), wb_we_i (in, 1), wb_adr_i (in, WB_ADR_BITS), wb_dat_i (in, 32) and wb_sel_i (in, 4).
REQ-007 SHALL have the WISHBONE target outputs wb_ack_o (out, 1), wb_err_o (out, 1), wb_rty_o (out, 1, tied 0) and wb_dat_o (out, 32).
REQ-008 SHALL have global_update_i (in, 1), a request to pulse update on all channels.
REQ-009 SHALL have coeff_dat_o (out, COEFF_BITS), the streamed coefficient, and coeff_adr_o (out, clog2(NCOEFF)), its index.
REQ-010 SHALL have coeff_wr_o (out, NCH), a one-hot per-channel write strobe.
REQ-011 SHALL have update_o (out, NCH), a per-channel one-cycle update pulse, and busy_o (out, 1), high while streaming.

Function
REQ-012 SHALL keep a shadow store of NCH*NCOEFF entries of COEFF_BITS; entry (c,k) sits at byte address 0x100 + 4*(c*NCOEFF+k).
REQ-013 SHALL decode 0x000 as CTRL: a write with bit0=1 commits the channel mask taken from bits [16+NCH-1:16]; reads return 0.
REQ-014 SHALL decode 0x004 as STATUS: read bit0=busy, bit1=sticky err, bits [16+NCH-1:16]=last committed mask; a write with bit1=1 clears err.
REQ-015 SHALL assert wb_ack_o (or wb_err_o) for exactly one cycle, in the cycle after wb_cyc_i&wb_stb_i is first seen, and SHALL drop it for one cycle before acknowledging a held strobe again.
REQ-016 SHALL present wb_dat_o together with the ack: the shadow value zero-extended, STATUS, or 0 for CTRL and unmapped addresses.
REQ-017 SHALL, on a shadow write with wb_sel_i[0]=1 while IDLE, store wb_dat_i[COEFF_BITS-1:0]; with wb_sel_i[0]=0 it SHALL ack without storing.
REQ-018 SHALL, on a shadow write or commit while not IDLE, answer with wb_err_o instead of wb_ack_o, drop the write and set err.
REQ-019 SHALL ack writes to unmapped addresses without side effect.
REQ-020 SHALL implement the states IDLE, STREAM and UPDATE.
REQ-021 SHALL move IDLE->STREAM on a commit with a nonzero mask, in the cycle after the ack, latching the mask; a zero mask SHALL be a no-op.
REQ-022 SHALL, in STREAM, service masked channels in ascending order and skip unmasked channels at zero cycle cost.
REQ-023 SHALL, in STREAM, emit NCOEFF consecutive cycles per serviced channel, with k=0..NCOEFF-1, coeff_adr_o=k, coeff_dat_o=shadow(c,k) and coeff_wr_o one-hot at bit c.
REQ-024 SHALL move STREAM->UPDATE after the last coefficient; UPDATE SHALL last one cycle, drive update_o equal to the latched mask, and then return to IDLE.
REQ-025 SHALL hold busy_o=1 in STREAM and UPDATE, giving a busy length of popcount(mask)*NCOEFF+1 cycles.
REQ-026 SHALL, when global_update_i is asserted in IDLE, pulse update_o to all ones in the next cycle.
REQ-027 SHALL, when global_update_i is asserted outside IDLE, latch it and pulse update_o to all ones in the first IDLE cycle; multiple requests SHALL merge into one pulse.
REQ-028 SHALL drive coeff_wr_o, coeff_dat_o and coeff_adr_o to 0 whenever the state is not STREAM.

Reset
REQ-029 SHALL, while rst_n_i=0, force the state to IDLE and drive every output to 0, including wb_ack_o, wb_err_o, wb_dat_o, coeff_*, update_o and busy_o.
REQ-030 SHALL, while rst_n_i=0, clear the shadow store, err, the latched mask and any pending global update.
REQ-031 SHALL, on reset during STREAM, abort with no update_o pulse, and SHALL leave IDLE only on a fresh commit.

Verification
REQ-032 SHALL cover this scenario: write 0x3FFFF to (c1,k2), read it back, reset, read again -> the data returns 0x0003FFFF, then 0x00000000.
REQ-033 SHALL cover this scenario: commit mask 0b0101 with NCH=4 and NCOEFF=8 -> 16 write cycles (ch0 k0..7, then ch2 k0..7), then update_o=0b0101 for one cycle, with busy_o high for 17 cycles.
REQ-034 SHALL cover this scenario: a shadow write during STREAM -> wb_err_o pulses, the shadow is unchanged and STATUS bit1=1; writing STATUS bit1=1 then reads bit1=0.
REQ-035 SHALL cover this scenario: global_update_i pulses twice during STREAM -> one update_o=0b1111 pulse arrives in the cycle after the UPDATE cycle.
REQ-036 SHALL cover this scenario: rst_n_i is asserted in the 5th STREAM cycle -> outputs go to 0 at once, no update_o appears, and busy_o=0.
REQ-037 SHALL cover this scenario: commit mask 0 and a read of 0x3F0 -> no busy_o, and the read returns 0 with ack.
